// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of the decode/EX hazard inputs and the sequencing outputs exchanged
// between the pipeline datapath (master) and the stall controller (slave).
interface hazard_stall_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       rs1addr;
    logic [4:0]       rs2addr;
    logic             use_rs1;
    logic             use_rs2;
    logic             EX_MemRead;
    logic [4:0]       EX_rdaddr;
    logic             EX_redirect;
    logic             imem_ready;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             IFFlush;
    logic             IDFlush;
    logic             ex_hold;
    logic             redirect_sel;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;

    modport master (
        output rs1addr, rs2addr, use_rs1, use_rs2, EX_MemRead, EX_rdaddr,
               EX_redirect, imem_ready, dmem_req, dmem_ready,
        input  pc_write, ifid_write, IFFlush, IDFlush, ex_hold, redirect_sel,
               mem_timeout, stall_cycles, flush_cycles
    );

    modport slave (
        input  rs1addr, rs2addr, use_rs1, use_rs2, EX_MemRead, EX_rdaddr,
               EX_redirect, imem_ready, dmem_req, dmem_ready,
        output pc_write, ifid_write, IFFlush, IDFlush, ex_hold, redirect_sel,
               mem_timeout, stall_cycles, flush_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core: arbitrates memory
// wait, EX redirect and load-use hazards, remembers redirects seen while the
// pipeline is frozen, watches for stuck memory waits and counts stall/flush
// cycles.
module hazard_stall_ctrl #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_stall_ctrl_if.slave bus
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             branch_pend_q, branch_pend_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mwait;
    logic lu;
    logic redir;
    logic rs1_hit;
    logic rs2_hit;

    logic pc_write;
    logic ifid_write;
    logic if_flush;
    logic id_flush;
    logic ex_hold;
    logic redirect_sel;

    // Hazard condition decode
    always_comb begin
        mwait   = (bus.dmem_req & ~bus.dmem_ready) | ~bus.imem_ready;
        rs1_hit = bus.use_rs1 & (bus.rs1addr == bus.EX_rdaddr);
        rs2_hit = bus.use_rs2 & (bus.rs2addr == bus.EX_rdaddr);
        lu      = bus.EX_MemRead & (bus.EX_rdaddr != '0) & (rs1_hit | rs2_hit);
        redir   = bus.EX_redirect | branch_pend_q;
    end

    // Next-state and sequencing outputs, priority: memory wait > redirect > load-use
    always_comb begin
        state_d       = state_q;
        branch_pend_d = branch_pend_q;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        if_flush      = 1'b0;
        id_flush      = 1'b0;
        ex_hold       = 1'b0;
        redirect_sel  = 1'b0;

        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            if_flush   = 1'b1;
            id_flush   = 1'b1;
        end else if (mwait) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ex_hold    = 1'b1;
            state_d    = MEM_WAIT;
            // EX is frozen, so a redirect resolved now must survive the wait
            if (bus.EX_redirect) begin
                branch_pend_d = 1'b1;
            end
        end else if (redir) begin
            if_flush      = 1'b1;
            id_flush      = 1'b1;
            redirect_sel  = 1'b1;
            branch_pend_d = 1'b0;
            state_d       = RUN;
        end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            id_flush   = 1'b1;
            state_d    = RUN;
        end else begin
            state_d = RUN;
        end
    end

    // Memory-wait watchdog: counts frozen cycles, latches a sticky timeout
    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        if (!mwait) begin
            wait_cnt_d = '0;
        end else if (state_q == MEM_WAIT) begin
            if (wait_cnt_q == WAIT_LAST) begin
                mem_timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 16'd1;
            end
        end
    end

    // Saturating stall/flush performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!rst && !pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (!rst && if_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            branch_pend_q <= 1'b0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            branch_pend_q <= branch_pend_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.ifid_write   = ifid_write;
    assign bus.IFFlush      = if_flush;
    assign bus.IDFlush      = id_flush;
    assign bus.ex_hold      = ex_hold;
    assign bus.redirect_sel = redirect_sel;
    assign bus.mem_timeout  = mem_timeout_q;
    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_cycles = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl with hand-computed expectations.
module tb_hazard_stall_ctrl;

    localparam int unsigned CNT_W = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    hazard_stall_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_stall_ctrl #(
        .TIMEOUT(4),
        .CNT_W  (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hif.rs1addr     = 5'd0;
        hif.rs2addr     = 5'd0;
        hif.use_rs1     = 1'b0;
        hif.use_rs2     = 1'b0;
        hif.EX_MemRead  = 1'b0;
        hif.EX_rdaddr   = 5'd0;
        hif.EX_redirect = 1'b0;
        hif.imem_ready  = 1'b1;
        hif.dmem_req    = 1'b0;
        hif.dmem_ready  = 1'b0;
    endtask

    // Advance to just after the next rising edge, ready for new inputs
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Compare the six sequencing outputs against a packed expectation
    task automatic check_seq(input string tag, input logic [5:0] exp);
        check({tag, ".seq{pc,ifid,iff,idf,hold,rsel}"},
              32'({hif.pc_write, hif.ifid_write, hif.IFFlush, hif.IDFlush,
                   hif.ex_hold, hif.redirect_sel}),
              32'(exp));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle();

        // Reset: outputs forced to flush/no-advance, registers cleared
        settle();
        check_seq("reset", 6'b001100);
        check("reset.stall", 32'(hif.stall_cycles), 0);
        check("reset.flush", 32'(hif.flush_cycles), 0);
        check("reset.tmo", 32'(hif.mem_timeout), 0);

        step();
        rst = 1'b0;
        settle();
        check_seq("idle", 6'b110000);

        // Load-use on rs1: one bubble
        step();
        hif.EX_MemRead = 1'b1; hif.EX_rdaddr = 5'd5; hif.rs1addr = 5'd5; hif.use_rs1 = 1'b1;
        settle();
        check_seq("lu_rs1", 6'b000100);
        step();
        hif.EX_MemRead = 1'b0;
        settle();
        check_seq("lu_release", 6'b110000);
        check("lu.stall", 32'(hif.stall_cycles), 1);

        // x0 destination never stalls
        step();
        idle();
        hif.EX_MemRead = 1'b1; hif.EX_rdaddr = 5'd0; hif.rs1addr = 5'd0; hif.use_rs1 = 1'b1;
        settle();
        check_seq("lu_x0", 6'b110000);

        // rs2 match but operand unused
        step();
        idle();
        hif.EX_MemRead = 1'b1; hif.EX_rdaddr = 5'd7; hif.rs2addr = 5'd7; hif.use_rs2 = 1'b0;
        settle();
        check_seq("lu_rs2_unused", 6'b110000);

        // rs2 match and used -> stall
        step();
        hif.use_rs2 = 1'b1;
        settle();
        check_seq("lu_rs2", 6'b000100);

        // Taken branch with a load-use present: redirect wins, load-use dropped
        step();
        hif.EX_redirect = 1'b1;
        settle();
        check_seq("branch", 6'b111101);
        step();
        idle();
        settle();
        check_seq("branch_after", 6'b110000);
        check("branch.flush", 32'(hif.flush_cycles), 1);
        check("branch.stall", 32'(hif.stall_cycles), 2);

        // Redirect arriving during a data wait is held, then applied on release
        step();
        hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0; hif.EX_redirect = 1'b1;
        settle();
        check_seq("dwait1", 6'b000010);
        step();
        hif.EX_redirect = 1'b0;
        settle();
        check_seq("dwait2", 6'b000010);
        step();
        settle();
        check_seq("dwait3", 6'b000010);
        step();
        hif.dmem_ready = 1'b1;
        settle();
        check_seq("dwait_release", 6'b111101);
        step();
        idle();
        settle();
        check_seq("dwait_after", 6'b110000);
        check("dwait.stall", 32'(hif.stall_cycles), 5);
        check("dwait.flush", 32'(hif.flush_cycles), 2);
        check("dwait.tmo", 32'(hif.mem_timeout), 0);

        // Fetch stall past TIMEOUT=4: flag rises after the 4th MEM_WAIT cycle
        for (int i = 1; i <= 6; i++) begin
            step();
            hif.imem_ready = 1'b0;
            settle();
            if (i == 1) check_seq("imem_wait", 6'b000010);
            if (i == 5) check("tmo.before", 32'(hif.mem_timeout), 0);
            if (i == 6) check("tmo.set", 32'(hif.mem_timeout), 1);
        end
        step();
        hif.imem_ready = 1'b1;
        settle();
        check_seq("imem_release", 6'b110000);
        check("tmo.sticky", 32'(hif.mem_timeout), 1);
        check("tmo.stall", 32'(hif.stall_cycles), 11);
        step();
        settle();
        check("tmo.sticky2", 32'(hif.mem_timeout), 1);

        // Reset in the middle of a wait with a pending redirect
        step();
        hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0; hif.EX_redirect = 1'b1;
        settle();
        check_seq("rstwait1", 6'b000010);
        step();
        hif.EX_redirect = 1'b0;
        rst = 1'b1;
        settle();
        check_seq("rst_mid", 6'b001100);
        step();
        rst = 1'b0;
        idle();
        settle();
        check_seq("rst_after", 6'b110000);
        check("rst.stall", 32'(hif.stall_cycles), 0);
        check("rst.flush", 32'(hif.flush_cycles), 0);
        check("rst.tmo", 32'(hif.mem_timeout), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard bound on run length
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32 core. Decides every cycle whether the PC and the IF/ID register advance, hold, or are flushed.
- Generates IDFlush for the decode stage and ex_hold for the downstream pipeline registers.
- Arbitrates three hazard sources by fixed priority: memory wait, then taken branch/jump, then load-use.
- Also keeps a pending-redirect register, a memory-wait timeout monitor, and saturating performance counters.

Parameters:
- TIMEOUT, 256: max consecutive MEM_WAIT cycles before mem_timeout is set (legal range 1..65535).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- rs1addr  in  5  rs1 field of the instruction currently in decode
- rs2addr  in  5  rs2 field of the instruction currently in decode
- use_rs1  in  1  decode instruction reads rs1
- use_rs2  in  1  decode instruction reads rs2
- EX_MemRead  in  1  instruction in EX is a load
- EX_rdaddr  in  5  destination register of the EX instruction
- EX_redirect  in  1  branch taken or jump resolved in EX this cycle
- imem_ready  in  1  instruction fetch completes this cycle
- dmem_req  in  1  MEM stage has a load or store outstanding
- dmem_ready  in  1  data access completes this cycle
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID register may load
- IFFlush  out  1  IF/ID register loads a NOP
- IDFlush  out  1  ID/EX control bits are cleared (bubble)
- ex_hold  out  1  ID/EX, EX/MEM and MEM/WB registers hold
- redirect_sel  out  1  PC mux selects the EX redirect target
- mem_timeout  out  1  sticky error flag
- stall_cycles  out  CNT_W  cycles with pc_write=0
- flush_cycles  out  CNT_W  cycles with IFFlush=1

Behaviour:
- FSM states: RUN, MEM_WAIT. State register, branch_pend, wait_cnt, mem_timeout and both counters are registered.
- All other outputs are combinational from the current state, registers and inputs (same-cycle response).
- Reset (rst=1 at posedge): state=RUN, branch_pend=0, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_cycles=0.
- Output values while rst is high: pc_write=0, ifid_write=0, IFFlush=1, IDFlush=1, ex_hold=0, redirect_sel=0.
- Definitions:
  - mwait = (dmem_req & ~dmem_ready) | ~imem_ready
  - lu = EX_MemRead & (EX_rdaddr!=0) & ((use_rs1 & rs1addr==EX_rdaddr) | (use_rs2 & rs2addr==EX_rdaddr))
  - redir = EX_redirect | branch_pend
- Priority 1, mwait=1 (either state):
  - pc_write=0, ifid_write=0, ex_hold=1, IFFlush=0, IDFlush=0, redirect_sel=0.
  - Next state MEM_WAIT. If EX_redirect=1, set branch_pend=1.
  - The EX instruction is frozen, so its redirect must not be lost.
- Priority 2, mwait=0 and redir=1:
  - pc_write=1, ifid_write=1, IFFlush=1, IDFlush=1, ex_hold=0, redirect_sel=1.
  - Clear branch_pend. Next state RUN.
- Priority 3, mwait=0, redir=0, lu=1:
  - pc_write=0, ifid_write=0, IDFlush=1, IFFlush=0, ex_hold=0, redirect_sel=0.
  - Next state RUN. Exactly one bubble per load-use pair, because the load then leaves EX.
- Otherwise: pc_write=1, ifid_write=1, all flush and hold outputs 0.
- wait_cnt:
  - Increments each cycle the state is MEM_WAIT and mwait=1.
  - Clears when mwait=0.
  - When wait_cnt reaches TIMEOUT-1 while mwait=1, mem_timeout is set. It clears only on rst.
  - The pipeline keeps waiting after timeout; it is not aborted.
- MEM_WAIT exits to RUN in the first cycle mwait=0. The release cycle applies priorities 2 and 3 normally.
- Counters:
  - stall_cycles increments on every non-reset cycle with pc_write=0.
  - flush_cycles increments on every cycle with IFFlush=1 and rst=0.
  - Both saturate at all-ones; no wrap.
- Register x0 never causes a load-use stall.
- A load-use condition present during a redirect is discarded, because the decode instruction is flushed.

Test Plan:
- Load-use: lw x5 in EX (EX_MemRead=1, EX_rdaddr=5), decode rs1addr=5, use_rs1=1 -> one cycle pc_write=0, ifid_write=0, IDFlush=1. Next cycle with EX_MemRead=0 -> pc_write=1. stall_cycles=1.
- x0 and unused operand: EX_rdaddr=0 with rs1addr=0, and separately rs2 match with use_rs2=0 -> no stall in either case.
- Taken branch: EX_redirect=1 -> IFFlush=1, IDFlush=1, redirect_sel=1, pc_write=1 for one cycle. flush_cycles=1.
- Redirect during data wait: dmem_req=1, dmem_ready=0 for 3 cycles, EX_redirect=1 in the first of them -> ex_hold=1 and redirect_sel=0 for 3 cycles. On the release cycle redirect_sel=1 and IFFlush=1, and branch_pend reads 0 afterwards.
- Timeout: TIMEOUT=4, imem_ready=0 for 6 cycles -> mem_timeout rises at the end of the 4th wait cycle and stays 1 after imem_ready=1.
- Reset mid-wait: assert rst during MEM_WAIT with branch_pend=1 -> next cycle state RUN, branch_pend=0, counters 0, mem_timeout=0. While rst is high, IFFlush=1 and IDFlush=1.
